// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the frame-level draw sequencer.
//   - state_e      : sequencer FSM states
//   - OBJ_*        : object index constants (player and four enemies)
//   - ERASE_COLOUR : colour the VGA path substitutes while erase is high
//   - idx_width()  : width of an object index for a given object count
package draw_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StUpdate,
    StSnap,
    StFin
  } state_e;

  localparam int unsigned OBJ_PLAYER = 0;
  localparam int unsigned OBJ_E0     = 1;
  localparam int unsigned OBJ_E1     = 2;
  localparam int unsigned OBJ_E2     = 3;
  localparam int unsigned OBJ_E3     = 4;

  localparam logic [2:0] ERASE_COLOUR = 3'b000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_sequencer_next_set_bit.sv
// Combinational priority encoder over the object mask.
// Ports:
//   mask       in  : candidate objects
//   idx        in  : current object; only bits strictly above it are considered
//   from_start in  : ignore idx and return the lowest set bit ("search from -1")
//   found      out : a qualifying bit exists
//   next_idx   out : index of the lowest qualifying bit (0 when none)
module draw_sequencer_next_set_bit #(
  parameter int unsigned NUM_OBJ = 5,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_OBJ-1:0] mask,
  input  logic [IDX_W-1:0]   idx,
  input  logic               from_start,
  output logic               found,
  output logic [IDX_W-1:0]   next_idx
);

  // Scan downwards so the last hit written is the lowest qualifying bit.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        found    = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level drawing controller. Per frame tick: erase last frame's objects,
// pulse update_en, snapshot obj_alive, draw the alive objects, pulse frame_done.
// Ports:
//   clk, reset (async, active low)
//   frame_tick     in  : frame start pulse (dropped and flagged if busy)
//   obj_alive      in  : objects to draw, sampled only in the snapshot state
//   done           in  : datapath finished the current object (honoured in WAIT only)
//   control_signal out : index of the object in progress, 0 when idle
//   draw_start     out : one-cycle restart of the datapath pixel walk
//   erase          out : high throughout the erase pass
//   plot           out : VGA write enable while waiting for done
//   update_en      out : one-cycle game-logic update strobe
//   frame_done     out : one-cycle end-of-frame pulse
//   busy           out : any state other than idle
//   overrun        out : one-cycle pulse, cycle after a dropped frame_tick
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 5,
  parameter int unsigned CTRL_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NUM_OBJ-1:0] obj_alive,
  input  logic               done,
  output logic [CTRL_W-1:0]  control_signal,
  output logic               draw_start,
  output logic               erase,
  output logic               plot,
  output logic               update_en,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned IDX_W = idx_width(NUM_OBJ);

  state_e             state_q, state_d;
  logic               pass_q, pass_d;       // 0 = erase pass, 1 = draw pass
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OBJ-1:0] mask_q, mask_d;
  logic [NUM_OBJ-1:0] prev_alive_q, prev_alive_d;
  logic               overrun_q, overrun_d;

  logic [NUM_OBJ-1:0] search_mask;
  logic               search_from_start;
  logic               search_found;
  logic [IDX_W-1:0]   search_idx;

  // One encoder serves all three lookups: lowest bit of prev_alive (IDLE),
  // lowest bit of obj_alive (SNAP) and next bit above idx (WAIT).
  always_comb begin
    search_mask       = mask_q;
    search_from_start = 1'b0;
    case (state_q)
      StIdle: begin
        search_mask       = prev_alive_q;
        search_from_start = 1'b1;
      end
      StSnap: begin
        search_mask       = obj_alive;
        search_from_start = 1'b1;
      end
      default: ;
    endcase
  end

  draw_sequencer_next_set_bit #(
    .NUM_OBJ (NUM_OBJ),
    .IDX_W   (IDX_W)
  ) u_next_set_bit (
    .mask       (search_mask),
    .idx        (idx_q),
    .from_start (search_from_start),
    .found      (search_found),
    .next_idx   (search_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pass_q       <= 1'b0;
      idx_q        <= '0;
      mask_q       <= '0;
      prev_alive_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      prev_alive_q <= prev_alive_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    prev_alive_d = prev_alive_q;
    overrun_d    = frame_tick && (state_q != StIdle);
    draw_start   = 1'b0;
    plot         = 1'b0;
    update_en    = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      StIdle: begin
        if (frame_tick) begin
          mask_d = prev_alive_q;
          pass_d = 1'b0;
          if (search_found) begin
            idx_d   = search_idx;
            state_d = StStart;
          end else begin
            state_d = StUpdate;
          end
        end
      end
      StStart: begin
        draw_start = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        plot = 1'b1;
        if (done) begin
          if (search_found) begin
            idx_d   = search_idx;
            state_d = StStart;
          end else if (!pass_q) begin
            state_d = StUpdate;
          end else begin
            state_d = StFin;
          end
        end
      end
      StUpdate: begin
        update_en = 1'b1;
        state_d   = StSnap;
      end
      StSnap: begin
        mask_d       = obj_alive;
        prev_alive_d = obj_alive;
        pass_d       = 1'b1;
        if (search_found) begin
          idx_d   = search_idx;
          state_d = StStart;
        end else begin
          state_d = StFin;
        end
      end
      StFin: begin
        frame_done = 1'b1;
        idx_d      = IDX_W'(OBJ_PLAYER);
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy           = (state_q != StIdle);
  assign erase          = ~pass_q & busy;
  assign control_signal = busy ? CTRL_W'(idx_q) : '0;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer. A frame-level model expands each
// requested frame into a per-cycle list of {inputs, expected outputs}; the
// list is then replayed against the DUT one cycle per record.
module tb_draw_sequencer;

  localparam int N  = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic [N-1:0]  obj_alive = '0;
  logic          done = 1'b0;
  logic [CW-1:0] control_signal;
  logic          draw_start, erase, plot, update_en, frame_done, busy, overrun;

  draw_sequencer #(
    .NUM_OBJ (N),
    .CTRL_W  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset_n),
    .frame_tick     (frame_tick),
    .obj_alive      (obj_alive),
    .done           (done),
    .control_signal (control_signal),
    .draw_start     (draw_start),
    .erase          (erase),
    .plot           (plot),
    .update_en      (update_en),
    .frame_done     (frame_done),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          tick;
    logic [N-1:0]  alive;
    logic          dn;
    logic [CW-1:0] ctrl;
    logic          ds, er, pl, up, fd, bz;
  } cyc_t;

  cyc_t q[$];
  cyc_t zero_tbl[5];

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc_no = 0;
  logic [N-1:0] m_prev = '0;    // model: objects drawn last frame
  int           m_cur = 0;      // model: last object touched this frame
  logic         last_tick_busy = 1'b0;
  bit           g_noise = 1'b0;
  bit           g_done_hi = 1'b0;

  function automatic cyc_t mk(input string tag, input bit tick, input logic [N-1:0] al,
                              input bit dn, input int ctrl, input bit ds, input bit er,
                              input bit pl, input bit up, input bit fd, input bit bz);
    cyc_t r;
    r.tag = tag; r.tick = tick; r.alive = al; r.dn = dn; r.ctrl = CW'(ctrl);
    r.ds = ds; r.er = er; r.pl = pl; r.up = up; r.fd = fd; r.bz = bz;
    return r;
  endfunction

  function automatic bit nz_tick();
    return g_noise && ($urandom_range(7) == 0);
  endfunction

  function automatic bit nz_done();
    if (g_done_hi) return 1'b1;
    return g_noise ? 1'($urandom_range(1)) : 1'b0;
  endfunction

  function automatic logic [N-1:0] nz_alive(input logic [N-1:0] base);
    return g_noise ? N'($urandom) : base;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d t=%0t: got %b expected %b", name, cyc_no, $time, got, exp);
    end
  endtask

  // One pass over objs in ascending index: START then len WAIT cycles per object.
  task automatic gen_pass(input logic [N-1:0] objs, input logic [N-1:0] base, input bit er,
                          input int lat, inout bit ovr);
    for (int i = 0; i < N; i++) begin
      if (objs[i]) begin
        int len;
        m_cur = i;
        q.push_back(mk("start", nz_tick(), nz_alive(base), nz_done(), i, 1, er, 0, 0, 0, 1));
        len = g_done_hi ? 1 : ((lat > 0) ? lat : int'($urandom_range(1, 4)));
        for (int j = 1; j <= len; j++) begin
          bit t;
          t = nz_tick();
          if (ovr) begin
            t   = 1'b1;
            ovr = 1'b0;
          end
          q.push_back(mk("wait", t, nz_alive(base), (j == len), i, 0, er, 1, 0, 0, 1));
        end
      end
    end
  endtask

  task automatic gen_frame(input logic [N-1:0] alive, input int lat, input int gap,
                           input bit force_ovr);
    bit ovr;
    ovr = force_ovr;
    for (int g = 0; g < gap; g++)
      q.push_back(mk("gap", 0, nz_alive(alive), nz_done(), 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("tick", 1, nz_alive(alive), nz_done(), 0, 0, 0, 0, 0, 0, 0));
    gen_pass(m_prev, alive, 1'b1, lat, ovr);
    q.push_back(mk("upd", nz_tick(), nz_alive(alive), nz_done(), m_cur, 0, 1, 0, 1, 0, 1));
    q.push_back(mk("snap", nz_tick(), alive, nz_done(), m_cur, 0, 1, 0, 0, 0, 1));
    m_prev = alive;
    gen_pass(alive, alive, 1'b0, lat, ovr);
    q.push_back(mk("fin", nz_tick(), nz_alive(alive), nz_done(), m_cur, 0, 0, 0, 0, 1, 1));
    m_cur = 0;
  endtask

  // Outputs packed as {control_signal, draw_start, erase, plot, update_en,
  // frame_done, busy, overrun}.
  task automatic play(input int n);
    cyc_t r;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      frame_tick = r.tick;
      obj_alive  = r.alive;
      done       = r.dn;
      @(negedge clk);
      cyc_no++;
      check(r.tag,
            {5'b0, control_signal, draw_start, erase, plot, update_en, frame_done, busy, overrun},
            {5'b0, r.ctrl, r.ds, r.er, r.pl, r.up, r.fd, r.bz, last_tick_busy});
      last_tick_busy = r.tick & r.bz;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {5'b0, control_signal, draw_start, erase, plot, update_en, frame_done, busy,
                 overrun}, 16'h0);
  endtask

  initial begin
    // Frame with obj_alive = 0 on both sides: tick, UPDATE, SNAP, FIN at k+3.
    zero_tbl[0] = mk("z_tick", 1, '0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_tbl[1] = mk("z_upd",  0, '0, 0, 0, 0, 1, 0, 1, 0, 1);
    zero_tbl[2] = mk("z_snap", 0, '0, 0, 0, 0, 1, 0, 0, 0, 1);
    zero_tbl[3] = mk("z_fin",  0, '0, 0, 0, 0, 0, 0, 0, 1, 1);
    zero_tbl[4] = mk("z_idle", 0, '0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset_n = 1'b1;

    // First frame: no erase pass, single draw of the player.
    gen_frame(5'b00001, 3, 1, 1'b0);
    play(q.size());
    // Second frame: erase idx 0, draw 0, 2, 4.
    gen_frame(5'b10101, 3, 0, 1'b0);
    play(q.size());
    // Empty frame after a populated one, then the fixed empty-to-empty table.
    gen_frame(5'b00000, 2, 1, 1'b0);
    play(q.size());
    for (int i = 0; i < 5; i++) q.push_back(zero_tbl[i]);
    play(q.size());

    // Tick dropped during WAIT.
    gen_frame(5'b01110, 3, 0, 1'b1);
    play(q.size());

    // done held high: two cycles per object, indices 0..4.
    g_done_hi = 1'b1;
    gen_frame(5'b11111, 1, 1, 1'b0);
    play(q.size());
    g_done_hi = 1'b0;

    // done low for a long stretch keeps the sequencer waiting.
    gen_frame(5'b00100, 25, 1, 1'b0);
    play(q.size());

    // Async reset in the middle of a WAIT.
    gen_frame(5'b00011, 6, 0, 1'b0);
    play(q.size() - 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_now");
    q.delete();
    m_prev = '0;
    m_cur = 0;
    last_tick_busy = 1'b0;
    frame_tick = 1'b0;
    done = 1'b0;
    @(negedge clk);
    check_all_zero("async_reset_held");
    reset_n = 1'b1;
    gen_frame(5'b10010, 2, 1, 1'b0);
    play(q.size());

    // Randomised frames with noise on every input outside its meaningful window.
    g_noise = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [N-1:0] al;
      al = ($urandom_range(3) == 0) ? '0 : N'($urandom);
      gen_frame(al, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
      play(q.size());
    end
    g_noise = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
